// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package data_mem_arbiter_pkg;

    localparam int DEF_WORD_LEN = 32;
    localparam int DEF_RD_LAT   = 1;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // Requester identity; also the value held in last_gnt.
    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Combinational 2-way round-robin picker between the pipeline (P) and debug (D) ports.
module data_mem_arbiter_rr
    import data_mem_arbiter_pkg::*;
(
    input  logic   req_p,
    input  logic   req_d,
    input  owner_t last_gnt,
    output logic   gnt_valid,
    output owner_t gnt_id
);

    // A lone requester always wins; on a tie the port not served last wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid = req_p | req_d;
        gnt_id    = OWN_P;
        if (req_p && req_d) begin
            gnt_id = (last_gnt == OWN_D) ? OWN_P : OWN_D;
        end else if (req_d) begin
            gnt_id = OWN_D;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-ported data memory between the pipeline MEM stage (P) and a
// debug/loader port (D). Each access is a non-overlapping IDLE->ISSUE->(WAIT)->RESP
// transaction; the owner gets a one-cycle ACK and its RDATA register is updated on reads.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                p_req,
    input  logic                p_we,
    input  logic [WORD_LEN-1:0] p_addr,
    input  logic [WORD_LEN-1:0] p_wdata,
    output logic                p_ack,
    output logic [WORD_LEN-1:0] p_rdata,
    output logic                pipe_stall,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_ack,
    output logic [WORD_LEN-1:0] d_rdata,

    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [WORD_LEN-1:0] mem_address,
    output logic [WORD_LEN-1:0] mem_data_in,
    input  logic [WORD_LEN-1:0] mem_data_out
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    arb_state_t          state, state_d;
    owner_t              owner, last_gnt, gnt_id;
    logic                gnt_valid;
    logic                accept, capture;
    logic                we_q;
    logic [WORD_LEN-1:0] addr_q, wdata_q;
    logic [CNT_W-1:0]    cnt;

    data_mem_arbiter_rr u_rr (
        .req_p     (p_req),
        .req_d     (d_req),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Next-state logic plus the accept/capture strobes used by the datapath.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    accept  = 1'b1;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_d = we_q ? ARB_RESP : ARB_WAIT;
            ARB_WAIT: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight without an ACK.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Latch the winner's command and remember who was served for round-robin.
    always_ff @(posedge clk) begin
        // NOTE: the command registers are reset because they drive the memory address/data ports directly.
        if (reset) begin
            owner    <= OWN_P;
            last_gnt <= OWN_D;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            owner    <= gnt_id;
            last_gnt <= gnt_id;
            we_q     <= (gnt_id == OWN_D) ? d_we    : p_we;
            addr_q   <= (gnt_id == OWN_D) ? d_addr  : p_addr;
            wdata_q  <= (gnt_id == OWN_D) ? d_wdata : p_wdata;
        end
    end

    // Read-latency counter: loaded on a read issue, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ARB_ISSUE && !we_q) begin
            cnt <= CNT_LOAD;
        end else if (state == ARB_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Per-port read data, updated only when a read for that port completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_rdata <= '0;
            d_rdata <= '0;
        end else if (capture) begin
            if (owner == OWN_D) begin
                d_rdata <= mem_data_out;
            end else begin
                p_rdata <= mem_data_out;
            end
        end
    end

    // Memory strobes exist only in ISSUE; address/data come straight from the latches.
    assign mem_write_en = (state == ARB_ISSUE) &&  we_q;
    assign mem_read_en  = (state == ARB_ISSUE) && !we_q;
    assign mem_address  = addr_q;
    assign mem_data_in  = wdata_q;

    assign p_ack      = (state == ARB_RESP) && (owner == OWN_P);
    assign d_ack      = (state == ARB_RESP) && (owner == OWN_D);
    assign pipe_stall = p_req & ~p_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with
// a latency-accurate memory model, random P/D requesters, random resets, and a
// transaction-level reference model predicting ACK timing, memory strobes and read data.
module tb_data_mem_arbiter;

    localparam int W    = 32;
    localparam int NCYC = 4000;

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         p_req [2], p_we [2], d_req [2], d_we [2];
    logic [W-1:0] p_addr [2], p_wdata [2], d_addr [2], d_wdata [2];
    logic         p_ack [2], d_ack [2], pipe_stall [2], mem_read_en [2], mem_write_en [2];
    logic [W-1:0] p_rdata [2], d_rdata [2], mem_address [2], mem_data_in [2], mem_data_out [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : unit
        localparam int RL = (g == 0) ? 1 : 3;
        bit   [W-1:0] dev_mem [256];
        logic [W-1:0] rd_pipe [RL];

        data_mem_arbiter #(.WORD_LEN(W), .RD_LAT(RL), .CNT_W(4)) dut (
            .clk          (clk),
            .reset        (reset),
            .p_req        (p_req[g]),
            .p_we         (p_we[g]),
            .p_addr       (p_addr[g]),
            .p_wdata      (p_wdata[g]),
            .p_ack        (p_ack[g]),
            .p_rdata      (p_rdata[g]),
            .pipe_stall   (pipe_stall[g]),
            .d_req        (d_req[g]),
            .d_we         (d_we[g]),
            .d_addr       (d_addr[g]),
            .d_wdata      (d_wdata[g]),
            .d_ack        (d_ack[g]),
            .d_rdata      (d_rdata[g]),
            .mem_read_en  (mem_read_en[g]),
            .mem_write_en (mem_write_en[g]),
            .mem_address  (mem_address[g]),
            .mem_data_in  (mem_data_in[g]),
            .mem_data_out (mem_data_out[g])
        );

        // Memory: write on WRITE_EN, read data appears RL cycles after READ_EN, junk otherwise.
        always @(posedge clk) begin
            if (mem_write_en[g]) dev_mem[mem_address[g][7:0]] <= mem_data_in[g];
            rd_pipe[0] <= mem_read_en[g] ? W'(dev_mem[mem_address[g][7:0]]) : W'($urandom);
            for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign mem_data_out[g] = rd_pipe[RL-1];
    end

    // Reference model state (transaction level, per unit).
    bit   [W-1:0] ref_mem [2][256];
    bit           m_pend [2], m_own_d [2], m_we [2], m_last_d [2];
    logic [W-1:0] m_addr [2], m_wdata [2], m_rdv [2], e_prd [2], e_drd [2];
    int           m_issue [2], m_ack [2], m_free [2];
    bit           ack_seen_p [2], ack_seen_d [2], busy_p [2], busy_d [2];
    bit           rst_seen, rst_prev, mon_en;
    int           n_acks = 0;

    // Monitor / scoreboard, sampling mid-cycle.
    initial begin
        int cyc;
        cyc = 0;
        for (int u = 0; u < 2; u++) begin
            m_pend[u] = 0; m_last_d[u] = 1; m_free[u] = 0; e_prd[u] = '0; e_drd[u] = '0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int u = 0; u < 2; u++) begin
                    bit ep, ed, ewe, ere, win_d;
                    if (!reset && !m_pend[u] && cyc >= m_free[u] && (p_req[u] || d_req[u])) begin
                        win_d       = (p_req[u] && d_req[u]) ? !m_last_d[u] : d_req[u];
                        m_last_d[u] = win_d;
                        m_own_d[u]  = win_d;
                        m_we[u]     = win_d ? d_we[u]    : p_we[u];
                        m_addr[u]   = win_d ? d_addr[u]  : p_addr[u];
                        m_wdata[u]  = win_d ? d_wdata[u] : p_wdata[u];
                        m_issue[u]  = cyc + 1;
                        m_ack[u]    = cyc + 2 + (m_we[u] ? 0 : lat_of(u));
                        if (m_we[u]) ref_mem[u][m_addr[u][7:0]] = m_wdata[u];
                        else         m_rdv[u] = ref_mem[u][m_addr[u][7:0]];
                        m_pend[u] = 1;
                    end
                    ep  = m_pend[u] && cyc == m_ack[u] && !m_own_d[u];
                    ed  = m_pend[u] && cyc == m_ack[u] &&  m_own_d[u];
                    ewe = m_pend[u] && cyc == m_issue[u] &&  m_we[u];
                    ere = m_pend[u] && cyc == m_issue[u] && !m_we[u];
                    if (ep && !m_we[u]) e_prd[u] = m_rdv[u];
                    if (ed && !m_we[u]) e_drd[u] = m_rdv[u];

                    check($sformatf("u%0d c%0d p_ack", u, cyc), W'(p_ack[u]), W'(ep));
                    check($sformatf("u%0d c%0d d_ack", u, cyc), W'(d_ack[u]), W'(ed));
                    check($sformatf("u%0d c%0d mem_write_en", u, cyc), W'(mem_write_en[u]), W'(ewe));
                    check($sformatf("u%0d c%0d mem_read_en", u, cyc), W'(mem_read_en[u]), W'(ere));
                    check($sformatf("u%0d c%0d pipe_stall", u, cyc), W'(pipe_stall[u]),
                          W'(p_req[u] & ~ep));
                    check($sformatf("u%0d c%0d p_rdata", u, cyc), p_rdata[u], e_prd[u]);
                    check($sformatf("u%0d c%0d d_rdata", u, cyc), d_rdata[u], e_drd[u]);
                    if (ewe || ere) begin
                        check($sformatf("u%0d c%0d mem_address", u, cyc), mem_address[u], m_addr[u]);
                        if (ewe) check($sformatf("u%0d c%0d mem_data_in", u, cyc), mem_data_in[u], m_wdata[u]);
                    end
                    if (rst_prev) begin
                        check($sformatf("u%0d c%0d mem_address after reset", u, cyc), mem_address[u], '0);
                        check($sformatf("u%0d c%0d mem_data_in after reset", u, cyc), mem_data_in[u], '0);
                    end

                    ack_seen_p[u] = p_ack[u];
                    ack_seen_d[u] = d_ack[u];
                    if (ep || ed) begin
                        n_acks++;
                        m_pend[u] = 0;
                        m_free[u] = cyc + 1;
                    end
                    if (reset) begin
                        m_pend[u] = 0; m_free[u] = cyc + 1; m_last_d[u] = 1;
                        e_prd[u] = '0; e_drd[u] = '0;
                    end
                end
                rst_prev = reset;
                rst_seen = reset;
            end
            cyc++;
        end
    end

    // One requester: finish on ACK (optionally refreshing at once), drop on reset, else maybe start.
    task automatic drive_port(input int u, input bit is_d);
        bit busy, ack;
        logic [W-1:0] a, wd;
        bit we;
        busy = is_d ? busy_d[u] : busy_p[u];
        ack  = is_d ? ack_seen_d[u] : ack_seen_p[u];
        if (rst_seen) busy = 0;
        else if (busy && ack) busy = 0;
        if (!busy && $urandom_range(0, 3) == 0) begin
            busy = 1;
            we   = 1'($urandom_range(0, 1));
            a    = $urandom() & 32'hFFFF_FF3C;
            wd   = $urandom();
            if (is_d) begin d_we[u] = we; d_addr[u] = a; d_wdata[u] = wd; end
            else      begin p_we[u] = we; p_addr[u] = a; p_wdata[u] = wd; end
        end
        if (is_d) begin busy_d[u] = busy; d_req[u] = busy; end
        else      begin busy_p[u] = busy; p_req[u] = busy; end
    endtask

    // Stimulus: initial reset, then random traffic with occasional reset pulses.
    initial begin
        reset  = 1'b1;
        mon_en = 1'b0;
        rst_seen = 1'b0;
        rst_prev = 1'b0;
        for (int u = 0; u < 2; u++) begin
            p_req[u] = 0; p_we[u] = 0; p_addr[u] = '0; p_wdata[u] = '0; busy_p[u] = 0;
            d_req[u] = 0; d_we[u] = 0; d_addr[u] = '0; d_wdata[u] = '0; busy_d[u] = 0;
        end
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 79) == 0);
            for (int u = 0; u < 2; u++) begin
                drive_port(u, 1'b0);
                drive_port(u, 1'b1);
            end
        end
        @(negedge clk);
        check("transactions completed", W'(n_acks > 200), W'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-ported data MEMORY between two requesters: the pipeline MEM stage (port P) and a debug/program-loader port (port D).
- Sequences each access as a non-overlapping transaction with a configurable read latency.
- Returns read data with a one-cycle acknowledge.
- Drives a stall to the pipeline while a P access is pending.

Parameters:
- WORD_LEN, `WORD_LEN (32): data and address width.
- RD_LAT, 1: cycles from read enable to valid memory DATA_OUT; legal range 1..15.
- CNT_W, 4: width of the latency counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- P_REQ  in  1  pipeline request; held until P_ACK.
- P_WE  in  1  1 = write, 0 = read; valid with P_REQ.
- P_ADDR  in  WORD_LEN  pipeline address (ALU result).
- P_WDATA  in  WORD_LEN  pipeline store operand.
- P_ACK  out  1  one-cycle transaction-complete pulse.
- P_RDATA  out  WORD_LEN  last read data for P.
- PIPE_STALL  out  1  freeze to the pipeline registers.
- D_REQ, D_WE, D_ADDR, D_WDATA  in  1/1/WORD_LEN/WORD_LEN  debug port, same rules as P.
- D_ACK, D_RDATA  out  1/WORD_LEN  debug port, same rules as P.
- MEM_READ_EN  out  1  to MEMORY READ_EN.
- MEM_WRITE_EN  out  1  to MEMORY WRITE_EN.
- MEM_ADDRESS  out  WORD_LEN  to MEMORY ADDRESS.
- MEM_DATA_IN  out  WORD_LEN  to MEMORY DATA_IN.
- MEM_DATA_OUT  in  WORD_LEN  from MEMORY DATA_OUT_REG.

Behaviour:
- State machine states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQ is high, the picker selects the winner.
  - The winner's WE, ADDR and WDATA are latched into internal registers; owner <= winner; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - MEM_ADDRESS and MEM_DATA_IN are driven from the latched registers.
  - MEM_WRITE_EN = latched WE; MEM_READ_EN = !latched WE.
  - Write: go to RESP.
  - Read: load cnt <= RD_LAT-1; go to WAIT.
- WAIT:
  - All memory enables are 0.
  - If cnt == 0: capture MEM_DATA_OUT into the owner's RDATA register; go to RESP.
  - Else cnt decrements.
- RESP (1 cycle):
  - The owner's ACK = 1; go to IDLE.
  - REQ sampled during RESP is ignored; a requester must drop or refresh REQ in the cycle after ACK.
- Latency from REQ rising in IDLE:
  - Write: ACK in cycle 2.
  - Read: ACK in cycle 2+RD_LAT (3 with default).
  - Back-to-back throughput: one access per 3 (write) or 3+RD_LAT (read) cycles.
- Arbitration: 2-way round-robin.
  - If only one REQ is high, it wins.
  - If both are high, the requester not served last wins.
  - last_gnt updates when the transaction is accepted in IDLE.
  - last_gnt resets to D, so P wins the first tie.
- PIPE_STALL = P_REQ & ~P_ACK (combinational).
  - The pipeline advances in the P_ACK cycle.
- Address and data pass through unmodified; no alignment or bounds check.
- P_RDATA and D_RDATA hold their value until the next read completes for that port; writes never alter them.
- Reset values: state IDLE, last_gnt D, cnt 0; all ACKs, MEM_READ_EN, MEM_WRITE_EN and PIPE_STALL-internal terms 0; MEM_ADDRESS, MEM_DATA_IN, P_RDATA, D_RDATA 0.
- RESET during ISSUE, WAIT or RESP:
  - Aborts the transaction; no ACK is issued.
  - The FSM is in IDLE the cycle after.
  - Requesters must reissue.
- A REQ that drops before ACK (protocol violation): the transaction still completes and ACK is still pulsed.

Decomposition:
- defines.v (shared):
  - `WORD_LEN.
  - State encodings `ARB_IDLE/`ARB_ISSUE/`ARB_WAIT/`ARB_RESP (2 bits).
  - Owner encoding `OWN_P=0/`OWN_D=1.
  - `DATA_MEM_RD_LAT default.
- Sub-module mem_rr_arbiter: combinational 2-way round-robin picker.
  - Inputs: REQ_P, REQ_D, LAST_GNT.
  - Outputs: GNT_VALID, GNT_ID.
- The top holds the FSM, latches, counter and RDATA registers.

Test Plan:
1. Reset, then P write addr 0x10 data 0xDEADBEEF alone -> MEM_WRITE_EN=1 with MEM_ADDRESS=0x10 and MEM_DATA_IN=0xDEADBEEF in cycle 1; P_ACK in cycle 2; PIPE_STALL high cycles 0-1, low in cycle 2.
2. P read addr 0x10 after scenario 1, RD_LAT=1 -> MEM_READ_EN pulse in cycle 1; P_ACK in cycle 3 with P_RDATA=0xDEADBEEF; D_RDATA stays 0.
3. P and D read requests rise in the same cycle after reset -> P served first (ACK cycle 3); D served next (issued in the cycle after P's RESP); D_ACK 4 cycles after P_ACK.
4. Both requesters hold REQ continuously for 6 transactions -> grants alternate P, D, P, D, P, D; no two consecutive ACKs to the same port.
5. RD_LAT=3, D read -> WAIT lasts 3 cycles; D_ACK in cycle 5; exactly one MEM_READ_EN pulse.
6. RESET asserted during WAIT of a P read -> no P_ACK; all outputs 0 the next cycle; a reissued P read completes normally with latency 2+RD_LAT.
